seq_det_ctrl: RTL
=================

// Module: seq_det_ctrl
// PURPOSE
//  Controller/scheduler for the bit-serial pattern detector: accepts bytes over a
//  valid/ready handshake and shifts them MSB-first, one bit per clk, into a
//  programmable overlapping pattern matcher.
//  Counts matches for software/status logic. Sits between a byte-wide source
//  (UART RX, FIFO) and the status/interrupt logic.
// PARAMETERS
//  PAT_W   4   pattern length in bits, legal 1..8
//  CNT_W   8   width of the match counter
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst        in   1      asynchronous, active-low reset
//  cfg_en     in   1      detector enable
//  cfg_pat    in   PAT_W  pattern; cfg_pat[PAT_W-1] is the first (oldest) bit
//  in_data    in   8      byte to scan
//  in_valid   in   1      in_data valid
//  in_ready   out  1      controller can accept a byte this cycle
//  match      out  1      one-cycle pulse per detected pattern occurrence
//  match_cnt  out  CNT_W  saturating count of matches
//  cnt_clr    in   1      synchronous clear of match_cnt
//  busy       out  1      byte currently being shifted
// BEHAVIOUR
//  Reset (rst=0, async)
//   - state=IDLE; bit_idx, hist, fill, match, match_cnt all 0.
//   - in_ready=0 and busy=0 while rst=0.
//  FSM states: IDLE, SHIFT
//   - IDLE:
//     - in_ready = cfg_en.
//     - Accept (in_valid & in_ready): latch in_data to sreg, latch cfg_pat to pat_q,
//       set bit_idx=7, go to SHIFT.
//     - If cfg_en=0 in IDLE: clear hist and fill.
//   - SHIFT:
//     - busy=1.
//     - Each cycle, bit b = sreg[bit_idx] enters the matcher; bit_idx decrements.
//     - At bit_idx==0: in_ready = cfg_en.
//       - Accept then: reload sreg, pat_q, bit_idx=7 and stay in SHIFT.
//       - Otherwise return to IDLE.
//     - Sustained throughput is 8 clk per byte with no bubbles.
//     - A cfg_en drop mid-byte does not abort the byte; it only blocks the next accept.
//  Matcher
//   - hist <= {hist[PAT_W-2:0], b}.
//   - fill saturates at PAT_W.
//   - hit = (fill_next >= PAT_W) && (hist_next == pat_q).
//   - Overlapping occurrences all count.
//   - hist persists across byte boundaries, so patterns may straddle bytes.
//  Latency
//   - match is registered: it pulses in the clk after the cycle in which the
//     completing bit was shifted.
//  Counter
//   - match_cnt increments on each match pulse.
//   - Saturates at 2^CNT_W-1; no wrap.
//   - cnt_clr has priority: a clear coincident with a match leaves match_cnt=0.
//  cfg_pat changes
//   - Take effect only at the next byte accept; the current byte uses pat_q.
//  in_valid without in_ready
//   - Ignored. The source must hold in_data until the handshake completes.
//  Reset mid-byte
//   - Abandons the byte and clears history.
//   - No match is produced for bits shifted before reset.
// STRUCTURE
//  Shared package seq_det_pkg
//   - state encoding localparams (IDLE=1'b0, SHIFT=1'b1)
//   - the PAT_W legal range
//  Sub-module pat_match (hist/fill shift register plus compare; outputs hit)
//   - Instantiated once by seq_det_ctrl.
//   - Same async active-low rst.
//  seq_det_ctrl owns the FSM, the handshake, sreg/bit_idx, the match register
//  and the counter.
// TESTING
//  1. PAT_W=4, pat=4'b1011, byte 8'hB0 -> exactly one match pulse, in the clk
//     after the 4th bit; match_cnt=1.
//  2. Overlap: pat=1011, byte 8'hB6 (10110110) -> two match pulses
//     (after bits 4 and 7); match_cnt=2.
//  3. Straddle: back-to-back bytes 8'h01, 8'h60 -> one match, after the 3rd bit
//     of byte 2.
//     - in_ready is high exactly on the 8th bit cycle of byte 1.
//     - No idle cycle between the two bytes.
//  4. Saturation/clear: CNT_W=2, five matching occurrences -> match_cnt holds 3.
//     - cnt_clr asserted in the same cycle as a match -> match_cnt=0.
//  5. Reset mid-operation: drop rst at bit 3 of 8'hB0.
//     - All outputs 0 immediately (async).
//     - After release, byte 8'h0B -> one match (no stale history).
//  6. cfg_en=0 during SHIFT -> current byte completes (busy falls after 8 bits).
//     - in_ready stays 0 and in_valid is ignored.

Source files
------------

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and limits for the bit-serial pattern detector
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int PAT_W_MIN = 1;
  localparam int PAT_W_MAX = 8;

endpackage

// File: rtl/seq_det_if.sv
// rtl/seq_det_if.sv - byte input handshake between the source and the detector
interface seq_det_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/seq_det_ctrl_pat_match.sv
// rtl/seq_det_ctrl_pat_match.sv - overlapping pattern matcher, history shift register plus compare
module pat_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             clr_i,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] pat_i,
  output logic             hit_o
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("pat_match: PAT_W out of legal range");
  end

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // hit looks at the post-shift history so the match register sees it one edge later
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    hit_o  = 1'b0;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en_i) begin
      hist_d = PAT_W'({hist_q, bit_i});
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
      hit_o  = (fill_d == FILL_MAX) && (hist_d == pat_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - byte scheduler feeding the pattern matcher MSB-first, with match counter
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic [PAT_W-1:0] cfg_pat,
  seq_det_if.slave         in_if,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             match_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready, accept, shift_en, hist_clr, hit;

  // in_ready is gated by rst so the source never sees a handshake during reset
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_idx_d = bit_idx_q;
    pat_d     = pat_q;
    in_ready  = 1'b0;
    shift_en  = 1'b0;
    hist_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rst & cfg_en;
        hist_clr = ~cfg_en;
      end
      SHIFT: begin
        shift_en  = 1'b1;
        bit_idx_d = bit_idx_q - 3'd1;
        in_ready  = rst & cfg_en & (bit_idx_q == 3'd0);
        if (bit_idx_q == 3'd0) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase
    accept = in_if.in_valid & in_ready;
    if (accept) begin
      sreg_d    = in_if.in_data;
      pat_d     = cfg_pat;
      bit_idx_d = 3'd7;
      state_d   = SHIFT;
    end
  end

  pat_match #(.PAT_W(PAT_W)) u_pat_match (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .clr_i      (hist_clr),
    .bit_i      (sreg_q[bit_idx_q]),
    .pat_i      (pat_q),
    .hit_o      (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_idx_q <= '0;
      pat_q     <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_idx_q <= bit_idx_d;
      pat_q     <= pat_d;
      match_q   <= hit;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (match_q && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_if.in_ready = in_ready;
  assign match          = match_q;
  assign match_cnt      = cnt_q;
  assign busy           = (state_q == SHIFT);

endmodule
